// File: rtl/accel_host_loader.sv
// ============================================================================
// accel_host_loader
//
// Host-side front end of the accelerator. Decodes a byte stream arriving on a
// valid/ready link into accelerator memory writes and 32-bit custom
// instructions. A WAIT_DONE command can stall the stream until the
// accelerator reports completion. This lets a single stream load data,
// configure the accelerator, trigger it and sequence several passes.
//
// Command set (opcode byte accepted in IDLE, multi-byte fields little-endian):
//   8'h01 SET_ADDR  : 3 bytes, write address <= field[ADDR_W-1:0]
//   8'h02 BURST     : 2-byte word count N, then N words of 3 bytes each.
//                     Each word is the low 18 bits of its 24-bit field.
//   8'h03 INSTR     : 4 bytes, presented on `instruction` for one cycle
//   8'h04 WAIT_DONE : stall (in_ready=0) until accel_done is sampled high
//   other           : sets sticky err, byte dropped
//
// Optional feature macro: ACCEL_LOADER_CHECKSUM_EN
//   When defined, every BURST (including N=0) is followed by one checksum
//   byte. The checksum is the XOR of all data bytes; the count bytes are not
//   included. A mismatch sets err. Words already written are kept.
//
// Parameters
//   ADDR_W                 width of the internal write-address register
//
// Ports
//   clk                    in   1   clock, all logic on posedge
//   rst                    in   1   synchronous active-high reset
//   in_data                in   8   stream byte
//   in_valid               in   1   in_data valid
//   in_ready               out  1   byte accepted when in_valid & in_ready
//   accel_done             in   1   accelerator pass complete (level)
//   instruction            out  32  instruction word, 32'h0 when idle
//   interface_write_addr   out  32  write address, zero-extended
//   interface_write_data   out  18  write data
//   interface_write_en     out  1   one-cycle write strobe
//   busy                   out  1   high whenever not in IDLE
//   err                    out  1   sticky protocol error, cleared by rst
// ============================================================================
module accel_host_loader #(
    parameter int ADDR_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        accel_done,
    output logic [31:0] instruction,
    output logic [31:0] interface_write_addr,
    output logic [17:0] interface_write_data,
    output logic        interface_write_en,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] OP_SET_ADDR  = 8'h01;
    localparam logic [7:0] OP_BURST     = 8'h02;
    localparam logic [7:0] OP_INSTR     = 8'h03;
    localparam logic [7:0] OP_WAIT_DONE = 8'h04;

`ifdef ACCEL_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CNT   = 3'd2,
        S_DATA  = 3'd3,
        S_INSTR = 3'd4,
        S_WAIT  = 3'd5,
        S_CSUM  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CNT   = 3'd2,
        S_DATA  = 3'd3,
        S_INSTR = 3'd4,
        S_WAIT  = 3'd5
    } state_t;
`endif

    state_t              r_state;
    state_t              w_next_state;

    // Byte index within the current field, and the bytes collected so far.
    // The final byte of a field is never stored; it is used straight from
    // in_data, so three bytes of storage are enough even for a 4-byte
    // instruction.
    logic [1:0]          r_idx;
    logic [23:0]         r_asm;

    logic [15:0]         r_cnt;
    logic [ADDR_W-1:0]   r_addr;

    logic                r_wr_en;
    logic [31:0]         r_wr_addr;
    logic [17:0]         r_wr_data;
    logic [31:0]         r_instr;
    logic                r_err;

`ifdef ACCEL_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
    logic                w_csum_end;
`endif

    logic                w_accept;
    logic                w_addr_end;
    logic                w_cnt_end;
    logic                w_word_end;
    logic                w_instr_end;
    logic                w_field_end;
    logic                w_bad_op;
    logic [15:0]         w_count;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (in_data)
                        OP_SET_ADDR:  w_next_state = S_ADDR;
                        OP_BURST:     w_next_state = S_CNT;
                        OP_INSTR:     w_next_state = S_INSTR;
                        OP_WAIT_DONE: w_next_state = S_WAIT;
                        default:      w_next_state = S_IDLE;
                    endcase
                end
            end
            S_ADDR: begin
                if (w_addr_end) w_next_state = S_IDLE;
            end
            S_CNT: begin
                if (w_cnt_end) begin
                    if (w_count != 16'd0) begin
                        w_next_state = S_DATA;
                    end else begin
`ifdef ACCEL_LOADER_CHECKSUM_EN
                        w_next_state = S_CSUM;
`else
                        w_next_state = S_IDLE;
`endif
                    end
                end
            end
            S_DATA: begin
                if (w_word_end && (r_cnt == 16'd1)) begin
`ifdef ACCEL_LOADER_CHECKSUM_EN
                    w_next_state = S_CSUM;
`else
                    w_next_state = S_IDLE;
`endif
                end
            end
            S_INSTR: begin
                if (w_instr_end) w_next_state = S_IDLE;
            end
            S_WAIT: begin
                if (accel_done) w_next_state = S_IDLE;
            end
`ifdef ACCEL_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_csum_end) w_next_state = S_IDLE;
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / decode logic
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready    = (r_state != S_WAIT);
        busy        = (r_state != S_IDLE);
        w_accept    = in_valid && in_ready;
        w_addr_end  = 1'b0;
        w_cnt_end   = 1'b0;
        w_word_end  = 1'b0;
        w_instr_end = 1'b0;
        w_bad_op    = 1'b0;
`ifdef ACCEL_LOADER_CHECKSUM_EN
        w_csum_end  = 1'b0;
`endif
        w_count     = {in_data, r_asm[7:0]};
        case (r_state)
            S_IDLE:  w_bad_op    = w_accept && ((in_data == 8'h00) || (in_data > OP_WAIT_DONE));
            S_ADDR:  w_addr_end  = w_accept && (r_idx == 2'd2);
            S_CNT:   w_cnt_end   = w_accept && (r_idx == 2'd1);
            S_DATA:  w_word_end  = w_accept && (r_idx == 2'd2);
            S_INSTR: w_instr_end = w_accept && (r_idx == 2'd3);
`ifdef ACCEL_LOADER_CHECKSUM_EN
            S_CSUM:  w_csum_end  = w_accept;
`endif
            default: ;
        endcase
`ifdef ACCEL_LOADER_CHECKSUM_EN
        w_field_end = w_addr_end || w_cnt_end || w_word_end || w_instr_end || w_csum_end;
`else
        w_field_end = w_addr_end || w_cnt_end || w_word_end || w_instr_end;
`endif
    end

    assign instruction          = r_instr;
    assign interface_write_addr = r_wr_addr;
    assign interface_write_data = r_wr_data;
    assign interface_write_en   = r_wr_en;
    assign err                  = r_err;

    // ------------------------------------------------------------------------
    // Field assembly storage. It needs no reset because the byte index is
    // reset, so a partial field left over from before rst is never used.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && (r_state != S_IDLE) && !w_field_end) begin
            case (r_idx)
                2'd0:    r_asm[7:0]   <= in_data;
                2'd1:    r_asm[15:8]  <= in_data;
                2'd2:    r_asm[23:16] <= in_data;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= 2'd0;
            r_cnt     <= 16'd0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 32'd0;
            r_wr_data <= 18'd0;
            r_instr   <= 32'd0;
            r_err     <= 1'b0;
`ifdef ACCEL_LOADER_CHECKSUM_EN
            r_csum    <= 8'd0;
`endif
        end else begin
            // Strobes default low, so each one lasts exactly one cycle.
            r_wr_en <= 1'b0;
            r_instr <= 32'd0;

            if (w_accept && (r_state != S_IDLE)) begin
                r_idx <= w_field_end ? 2'd0 : (r_idx + 2'd1);
            end

            if (w_bad_op) begin
                r_err <= 1'b1;
            end

            if (w_addr_end) begin
                r_addr <= ADDR_W'({in_data, r_asm[15:0]});
            end

            if (w_cnt_end) begin
                r_cnt <= w_count;
            end

            if (w_word_end) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= 32'(r_addr);
                r_wr_data <= {in_data[1:0], r_asm[15:0]};
                // Natural wrap at 2^ADDR_W.
                r_addr    <= r_addr + 1'b1;
                r_cnt     <= r_cnt - 16'd1;
            end

            if (w_instr_end) begin
                r_instr <= {in_data, r_asm};
            end

`ifdef ACCEL_LOADER_CHECKSUM_EN
            // Restart the running XOR on every accepted opcode. It only
            // matters for a BURST, and restarting it always keeps the
            // logic simple.
            if (w_accept && (r_state == S_IDLE)) begin
                r_csum <= 8'd0;
            end else if (w_accept && (r_state == S_DATA)) begin
                r_csum <= r_csum ^ in_data;
            end

            if (w_csum_end && (in_data != r_csum)) begin
                r_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_accel_host_loader.sv
module tb_accel_host_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        accel_done;
    logic [31:0] instruction;
    logic [31:0] interface_write_addr;
    logic [17:0] interface_write_data;
    logic        interface_write_en;
    logic        busy;
    logic        err;

    accel_host_loader #(.ADDR_W(20)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .accel_done           (accel_done),
        .instruction          (instruction),
        .interface_write_addr (interface_write_addr),
        .interface_write_data (interface_write_data),
        .interface_write_en   (interface_write_en),
        .busy                 (busy),
        .err                  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [17:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] iq[$];
    wr_t         mon_e;
    logic [31:0] mon_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%h expected=none", name, act);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [17:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) unexpected("send_timeout", {24'd0, b});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: compares every presented write/instruction
    // against the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (interface_write_en) begin
                if (wq.size() == 0) begin
                    unexpected("wr_unexpected", interface_write_addr);
                end else begin
                    mon_e = wq.pop_front();
                    check("wr_addr", interface_write_addr, mon_e.a);
                    check("wr_data", {14'd0, interface_write_data}, {14'd0, mon_e.d});
                end
            end
            if (instruction != 32'd0) begin
                if (iq.size() == 0) begin
                    unexpected("instr_unexpected", instruction);
                end else begin
                    mon_i = iq.pop_front();
                    check("instr", instruction, mon_i);
                end
            end
            if (interface_write_en && (instruction != 32'd0)) begin
                unexpected("wr_instr_overlap", instruction);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    int wait_bad;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        accel_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_wr_en", {31'd0, interface_write_en}, 32'd0);
        check("rst_wr_addr", interface_write_addr, 32'd0);

        // T1: set address, burst of two words
        push_wr(32'h0000_1000, 18'h00005);
        push_wr(32'h0000_1001, 18'h3FFFF);
        send(8'h01); send(8'h00); send(8'h10); send(8'h00);
        send(8'h02); send(8'h02); send(8'h00);
        send(8'h05); send(8'h00); send(8'h00);
        send(8'hFF); send(8'hFF); send(8'h03);
`ifdef ACCEL_LOADER_CHECKSUM_EN
        send(8'h06);
`endif
        idle(2);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // T2: instruction, with an in_valid gap mid-field
        iq.push_back(32'h0F00_000B);
        send(8'h03); send(8'h0B);
        idle(5);
        check("t2_hold_busy", {31'd0, busy}, 32'd1);
        send(8'h00); send(8'h00); send(8'h0F);
        idle(3);

        // T3: WAIT_DONE with done low for 20 cycles
        accel_done = 1'b0;
        send(8'h04);
        wait_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready || !busy) wait_bad++;
            @(posedge clk);
            #1;
        end
        check("t3_wait_stall", wait_bad, 32'd0);
        accel_done = 1'b1;
        check("t3_ready_before_sample", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("t3_ready_after_done", {31'd0, in_ready}, 32'd1);
        check("t3_busy_after_done", {31'd0, busy}, 32'd0);

        // WAIT_DONE with done already high: exactly one cycle stalled
        send(8'h04);
        check("t3b_wait_one", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("t3b_ready", {31'd0, in_ready}, 32'd1);
        accel_done = 1'b0;

        // T4: address wrap at 2^20
        push_wr(32'h000F_FFFF, 18'h00001);
        push_wr(32'h0000_0000, 18'h00002);
        push_wr(32'h0000_0001, 18'h00003);
        send(8'h01); send(8'hFF); send(8'hFF); send(8'h0F);
        send(8'h02); send(8'h03); send(8'h00);
        send(8'h01); send(8'h00); send(8'h00);
        send(8'h02); send(8'h00); send(8'h00);
        send(8'h03); send(8'h00); send(8'h00);
`ifdef ACCEL_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        idle(2);

        // Burst with N=0: no writes, back to IDLE
        send(8'h02); send(8'h00); send(8'h00);
`ifdef ACCEL_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        idle(2);
        check("n0_busy", {31'd0, busy}, 32'd0);
        check("n0_err", {31'd0, err}, 32'd0);

        // T5: illegal opcode is sticky, following command still works
        send(8'h7E);
        check("t5_err_set", {31'd0, err}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        iq.push_back(32'h1234_5678);
        send(8'h03); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        idle(2);
        check("t5_err_sticky", {31'd0, err}, 32'd1);

        // Reset after two bytes of a burst word
        send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        send(8'h02); send(8'h01); send(8'h00);
        send(8'hAB); send(8'hCD);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_rst_err", {31'd0, err}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_wr_en", {31'd0, interface_write_en}, 32'd0);
        idle(3);
        // Address register was cleared: next write lands at 0
        push_wr(32'h0000_0000, 18'h00011);
        send(8'h02); send(8'h01); send(8'h00);
        send(8'h11); send(8'h00); send(8'h00);
`ifdef ACCEL_LOADER_CHECKSUM_EN
        send(8'h11);
`endif
        idle(2);

`ifdef ACCEL_LOADER_CHECKSUM_EN
        // T6: checksum good then bad
        push_wr(32'h0000_0001, 18'h13412);
        send(8'h02); send(8'h01); send(8'h00);
        send(8'h12); send(8'h34); send(8'h01);
        send(8'h27);
        idle(2);
        check("t6_good_err", {31'd0, err}, 32'd0);
        push_wr(32'h0000_0002, 18'h13412);
        send(8'h02); send(8'h01); send(8'h00);
        send(8'h12); send(8'h34); send(8'h01);
        send(8'h00);
        idle(2);
        check("t6_bad_err", {31'd0, err}, 32'd1);
`endif

        idle(4);
        check("wq_drained", wq.size(), 32'd0);
        check("iq_drained", iq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
